cpu_run_sequencer: RTL and testbench
====================================

Name: cpu_run_sequencer

Overview:
- Upstream launch controller for the lab3 CPU core; replaces bench-driven start pulsing.
- Holds a small table of program start addresses and launches each program in turn: one-cycle start_i pulse with start_addr driven, then waits for done.
- Measures the dynamic cycle count of every program; flags a hung program with a timeout.
- Reports overall completion to the system/bench.

Parameters:
- NUM_PROGS, 3, number of table entries/programs per run (1..16)
- ADDR_W, 8, CPU start address width
- CNT_W, 15, cycle counter width
- TIMEOUT, 20000, max RUN cycles before abort; must be < 2^CNT_W - 1

Ports:
- clock_i  in  1  rising-edge clock
- reset_i  in  1  synchronous, active-high reset
- run_i  in  1  one-cycle request to start the sequence; honoured only in IDLE or FINISH
- cfg_we_i  in  1  table write strobe
- cfg_idx_i  in  4  table entry index
- cfg_addr_i  in  ADDR_W  start address to store
- cpu_done_i  in  1  done from the CPU core
- cpu_start_o  out  1  start pulse to the CPU core
- cpu_start_addr_o  out  ADDR_W  start address to the CPU core
- busy_o  out  1  sequencer in LAUNCH or RUN
- prog_idx_o  out  4  index of the current/last program
- cycle_count_o  out  CNT_W  count of the last completed program
- count_valid_o  out  1  one-cycle pulse when cycle_count_o updates
- all_done_o  out  1  all programs finished, held in FINISH
- timeout_o  out  1  sticky; program aborted on timeout

Behaviour:
- Reset: state IDLE.
  - All outputs 0.
  - Table entries 0.
  - Internal counter and index cleared.
- FSM states: IDLE, LAUNCH, RUN, FINISH.
- IDLE or FINISH with run_i=1:
  - Next state LAUNCH.
  - idx=0; timeout_o and all_done_o cleared.
- LAUNCH (exactly one cycle):
  - cpu_start_o=1; cpu_start_addr_o=table[idx].
  - Counter cleared to 0.
  - Next state RUN.
  - cpu_done_i is ignored in this cycle, which masks a stale done from the previous program.
- RUN: counter increments every cycle; cpu_start_o=0.
  - cpu_start_addr_o holds table[idx] throughout RUN.
- RUN with cpu_done_i=1:
  - cycle_count_o = counter+1, i.e. cycles from the first RUN cycle through the done cycle inclusive; done in the first RUN cycle gives 1.
  - count_valid_o pulses in the following cycle.
  - If idx==NUM_PROGS-1, next state FINISH; otherwise idx increments and next state LAUNCH.
  - Between consecutive programs there is exactly one LAUNCH cycle (zero idle gap).
- RUN with counter+1 == TIMEOUT and no done:
  - timeout_o=1 (sticky).
  - cycle_count_o=TIMEOUT; count_valid_o pulses.
  - Next state IDLE; the remaining programs are skipped and all_done_o stays 0.
- Done and timeout in the same cycle: done wins and timeout_o is not set.
- FINISH: all_done_o=1 and busy_o=0, held until run_i or reset.
- busy_o=1 exactly in LAUNCH and RUN.
- prog_idx_o=idx at all times.
- Table writes:
  - Accepted only in IDLE/FINISH and only when cfg_idx_i < NUM_PROGS; otherwise silently dropped.
  - A write and run_i in the same cycle: the write lands first and the launch uses the new value.
- run_i while busy is ignored.
- reset_i mid-run returns the block to the reset state next edge.
- cpu_start_o is registered: no combinational path from any input to any output.

Optional Feature:
- Macro: SEQ_CYCLE_LOG_EN.
- Defined: adds a per-program count log.
  - Extra ports: log_idx_i (in, 4) and log_count_o (out, CNT_W).
  - log_count_o = log[log_idx_i], combinational read.
  - An entry is written whenever count_valid_o fires.
  - The log is cleared on reset and on run_i acceptance.
  - An out-of-range log_idx_i reads 0.
- Undefined: those ports and storage are absent; only cycle_count_o is available.

Decomposition:
- Package cpu_seq_pkg:
  - state enum (IDLE, LAUNCH, RUN, FINISH)
  - default parameter constants: ADDR_W, CNT_W, TIMEOUT
- One natural sub-module, seq_addr_table: NUM_PROGS x ADDR_W register file with guarded write and combinational read, shared by the optional log (instantiated with CNT_W width).

Test Plan:
- Reset, write table {0,93,138}, pulse run_i; the CPU model asserts done 10/25/7 cycles after each start → start pulses at addresses 0, 93, 138; counts 10, 25, 7, each flagged by count_valid_o; all_done_o=1 after the third.
- Stale done: cpu_done_i held high through the LAUNCH cycle, done again 4 RUN cycles later → count=4, not 0 or 1.
- Hung CPU with TIMEOUT=50 → timeout_o=1 and cycle_count_o=50; state IDLE, prog_idx_o=0, all_done_o=0; a fresh run_i clears timeout_o.
- cfg_we_i during RUN (idx 1, addr 0xFF) and cfg_idx_i=5 in IDLE → both ignored; the second launch still uses 93.
- reset_i asserted in the 3rd RUN cycle of program 1 → next edge: all outputs 0, busy_o=0, table zeroed.
- With SEQ_CYCLE_LOG_EN, after the first scenario: log_idx_i 0/1/2/3 → log_count_o 10/25/7/0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and default constants for the CPU run sequencer.
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  localparam int NUM_PROGS_DEF = 3;
  localparam int ADDR_W_DEF    = 8;
  localparam int CNT_W_DEF     = 15;
  localparam int TIMEOUT_DEF   = 20000;
  localparam int IDX_W         = 4;

endpackage

// File: rtl/seq_addr_table.sv
// Small N x W register file: guarded write, combinational read, synchronous clear.
// Out-of-range write indices are dropped and out-of-range reads return 0.
module seq_addr_table
  import cpu_seq_pkg::*;
#(
  parameter int N = NUM_PROGS_DEF,
  parameter int W = ADDR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < N; i++) begin
        if (widx_i == IDX_W'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N; i++) begin
      if (ridx_i == IDX_W'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Launches each program from the start-address table in turn, times it, and aborts hung programs.
// Optional per-program count log when SEQ_CYCLE_LOG_EN is defined.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int NUM_PROGS = NUM_PROGS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              cfg_we_i,
  input  logic [3:0]        cfg_idx_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic              cpu_done_i,
  output logic              cpu_start_o,
  output logic [ADDR_W-1:0] cpu_start_addr_o,
  output logic              busy_o,
  output logic [3:0]        prog_idx_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic              count_valid_o,
  output logic              all_done_o,
  output logic              timeout_o,
`ifdef SEQ_CYCLE_LOG_EN
  input  logic [3:0]        log_idx_i,
  output logic [CNT_W-1:0]  log_count_o,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_PROGS - 1);

  seq_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             accept_run;
  logic             cfg_open;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc  = cnt_q + 1'b1;
  assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_FINISH);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // LAUNCH ignores cpu_done_i so a done still high from the previous program is not counted.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    accept_run = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (run_i) begin
          accept_run = 1'b1;
          state_d    = ST_LAUNCH;
          idx_d      = '0;
          timeout_d  = 1'b0;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (cpu_done_i) begin
          count_d = cnt_inc;
          valid_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LAUNCH;
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          count_d   = TIMEOUT_C;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seq_addr_table #(.N(NUM_PROGS), .W(ADDR_W)) u_addr_table (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (1'b0),
    .we_i    (cfg_we_i && cfg_open),
    .widx_i  (cfg_idx_i),
    .wdata_i (cfg_addr_i),
    .ridx_i  (idx_q),
    .rdata_o (cpu_start_addr_o)
  );

`ifdef SEQ_CYCLE_LOG_EN
  // Each entry is written on the same edge that raises count_valid_o.
  seq_addr_table #(.N(NUM_PROGS), .W(CNT_W)) u_count_log (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (accept_run),
    .we_i    (valid_d),
    .widx_i  (idx_q),
    .wdata_i (count_d),
    .ridx_i  (log_idx_i),
    .rdata_o (log_count_o)
  );
`endif

  assign cpu_start_o   = (state_q == ST_LAUNCH);
  assign busy_o        = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
  assign all_done_o    = (state_q == ST_FINISH);
  assign prog_idx_o    = idx_q;
  assign cycle_count_o = count_q;
  assign count_valid_o = valid_q;
  assign timeout_o     = timeout_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer with a small CPU done model and count scoreboard.
module tb_cpu_run_sequencer;

  localparam int NUM_PROGS = 3;
  localparam int ADDR_W    = 8;
  localparam int CNT_W     = 15;
  localparam int TIMEOUT   = 50;

  logic              clk;
  logic              reset_i;
  logic              run_i;
  logic              cfg_we_i;
  logic [3:0]        cfg_idx_i;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic              cpu_done_i;
  logic              cpu_start_o;
  logic [ADDR_W-1:0] cpu_start_addr_o;
  logic              busy_o;
  logic [3:0]        prog_idx_o;
  logic [CNT_W-1:0]  cycle_count_o;
  logic              count_valid_o;
  logic              all_done_o;
  logic              timeout_o;
  logic [1:0]        dbg_state_o;
`ifdef SEQ_CYCLE_LOG_EN
  logic [3:0]        log_idx_i;
  logic [CNT_W-1:0]  log_count_o;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  cpu_run_sequencer #(
    .NUM_PROGS(NUM_PROGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_i          (clk),
    .reset_i          (reset_i),
    .run_i            (run_i),
    .cfg_we_i         (cfg_we_i),
    .cfg_idx_i        (cfg_idx_i),
    .cfg_addr_i       (cfg_addr_i),
    .cpu_done_i       (cpu_done_i),
    .cpu_start_o      (cpu_start_o),
    .cpu_start_addr_o (cpu_start_addr_o),
    .busy_o           (busy_o),
    .prog_idx_o       (prog_idx_o),
    .cycle_count_o    (cycle_count_o),
    .count_valid_o    (count_valid_o),
    .all_done_o       (all_done_o),
    .timeout_o        (timeout_o),
`ifdef SEQ_CYCLE_LOG_EN
    .log_idx_i        (log_idx_i),
    .log_count_o      (log_count_o),
`endif
    .dbg_state_o      (dbg_state_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_start"},    32'(cpu_start_o), 0);
    chk({tag, "_addr"},     32'(cpu_start_addr_o), 0);
    chk({tag, "_busy"},     32'(busy_o), 0);
    chk({tag, "_idx"},      32'(prog_idx_o), 0);
    chk({tag, "_count"},    32'(cycle_count_o), 0);
    chk({tag, "_valid"},    32'(count_valid_o), 0);
    chk({tag, "_all_done"}, 32'(all_done_o), 0);
    chk({tag, "_timeout"},  32'(timeout_o), 0);
    chk({tag, "_state"},    32'(dbg_state_o), 0);
  endtask

  // driver tasks: set inputs, take one edge, release at #1
  task automatic cfg_write(input int idx, input int addr);
    cfg_we_i = 1'b1; cfg_idx_i = 4'(idx); cfg_addr_i = 8'(addr);
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic pulse_run();
    run_i = 1'b1;
    @(posedge clk); #1;
    run_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && !cpu_start_o; i++) @(negedge clk);
    chk("start_seen", 32'(cpu_start_o), 1);
  endtask

  // Called at a negedge inside (or shortly before) a LAUNCH cycle; CPU raises done d cycles after start.
  task automatic do_prog(input int d, input int exp_idx, input int exp_addr,
                         input bit last, input bit wr_during_run);
    wait_start();
    chk("launch_addr", 32'(cpu_start_addr_o), 32'(exp_addr));
    chk("launch_idx",  32'(prog_idx_o), 32'(exp_idx));
    chk("launch_busy", 32'(busy_o), 1);
    exp_q.push_back(32'(d));
    cfg_idx_i  = 4'd1;
    cfg_addr_i = 8'hFF;
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      cfg_we_i = wr_during_run && (i == 0);
    end
    cpu_done_i = 1'b1;
    @(posedge clk); #1;
    cpu_done_i = 1'b0;
    @(negedge clk);
    chk("count_valid", 32'(count_valid_o), 1);
    chk("cycle_count", 32'(cycle_count_o), exp_q.pop_front());
    chk("all_done",    32'(all_done_o), 32'(last));
    chk("busy_after",  32'(busy_o), last ? 0 : 1);
  endtask

  initial begin
    int n;
    reset_i = 1'b1; run_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
    cfg_addr_i = '0; cpu_done_i = 1'b0;
`ifdef SEQ_CYCLE_LOG_EN
    log_idx_i = '0;
`endif
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk_quiet("reset");

    // normal three-program run
    cfg_write(0, 0);
    cfg_write(1, 93);
    cfg_write(2, 138);
    @(negedge clk);
    pulse_run();
    do_prog(10, 0, 0,   1'b0, 1'b0);
    do_prog(25, 1, 93,  1'b0, 1'b0);
    do_prog(7,  2, 138, 1'b1, 1'b0);
    chk("finish_state", 32'(dbg_state_o), 3);
    @(negedge clk);
    chk("finish_hold", 32'(all_done_o), 1);
    chk("valid_pulse_once", 32'(count_valid_o), 0);
`ifdef SEQ_CYCLE_LOG_EN
    log_idx_i = 4'd0; #1 chk("log0", 32'(log_count_o), 10);
    log_idx_i = 4'd1; #1 chk("log1", 32'(log_count_o), 25);
    log_idx_i = 4'd2; #1 chk("log2", 32'(log_count_o), 7);
    log_idx_i = 4'd3; #1 chk("log3", 32'(log_count_o), 0);
`endif

    // stale done held through LAUNCH, real done in the 4th RUN cycle
    cpu_done_i = 1'b1;
    run_i = 1'b1;
    @(posedge clk); #1;
    run_i = 1'b0;
    chk("stale_launch", 32'(cpu_start_o), 1);
    @(posedge clk); #1;
    cpu_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 cpu_done_i = 1'b1;
    @(posedge clk); #1;
    cpu_done_i = 1'b0;
    @(negedge clk);
    chk("stale_valid", 32'(count_valid_o), 1);
    chk("stale_count", 32'(cycle_count_o), 4);
    do_prog(3, 1, 93,  1'b0, 1'b0);
    do_prog(2, 2, 138, 1'b1, 1'b0);

    // hung CPU -> timeout
    pulse_run();
    chk("to_all_done_cleared", 32'(all_done_o), 0);
    n = 0;
    while (!count_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles",   32'(n), 51);
    chk("to_flag",     32'(timeout_o), 1);
    chk("to_count",    32'(cycle_count_o), 50);
    chk("to_state",    32'(dbg_state_o), 0);
    chk("to_idx",      32'(prog_idx_o), 0);
    chk("to_all_done", 32'(all_done_o), 0);
    chk("to_busy",     32'(busy_o), 0);
    @(negedge clk);
    chk("to_sticky", 32'(timeout_o), 1);

    // out-of-range write in IDLE, write during RUN; both must be dropped
    cfg_write(5, 8'hFF);
    @(negedge clk);
    pulse_run();
    chk("rerun_timeout_clr", 32'(timeout_o), 0);
    do_prog(6, 0, 0,   1'b0, 1'b1);
    do_prog(4, 1, 93,  1'b0, 1'b0);
    do_prog(3, 2, 138, 1'b1, 1'b0);

    // reset in the 3rd RUN cycle of program 1
    pulse_run();
    do_prog(2, 0, 0, 1'b0, 1'b0);
    chk("rst_launch1_addr", 32'(cpu_start_addr_o), 93);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk_quiet("midrst");
    pulse_run();
    do_prog(2, 0, 0, 1'b0, 1'b0);
    do_prog(2, 1, 0, 1'b0, 1'b0);
    do_prog(2, 2, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
